// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, score width and limit, saturating score step.
package game_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DEAD = 2'd2;
    localparam logic [STATE_W-1:0] OVER = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DEAD = DEAD,
        S_OVER = OVER
    } game_state_t;

    localparam int                 SCORE_W   = 14;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Player button conditioning: two-flop synchroniser, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int               CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             sync_prev;
    logic             lvl;
    logic             lvl_prev;
    logic [CNT_W-1:0] stable_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            sync_prev  <= 1'b0;
            stable_cnt <= '0;
            lvl        <= 1'b0;
            lvl_prev   <= 1'b0;
            press      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_out  <= sync_meta;
            sync_prev <= sync_out;
            // Any change restarts the window; the level is taken once the count saturates.
            if (sync_out != sync_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_LAST) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                lvl <= sync_out;
            end
            lvl_prev <= lvl;
            press    <= lvl & ~lvl_prev;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Runner game sequencer: button debounce, IDLE/RUN/DEAD/OVER FSM, scroll control and score.
// Define GAME_CTRL_HIGH_SCORE_EN to build the high-score register; otherwise high_score is 0.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLDOFF_CYC  = 50_000_000,
    parameter int SCORE_CYC    = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    input  logic               collision,
    output logic               scroll_halt,
    output logic               scroll_reset,
    output logic               jump_req,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int                TICK_W    = (SCORE_CYC > 1) ? $clog2(SCORE_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCORE_CYC - 1);
    localparam int                HOLD_W    = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC - 1);

    logic rst_meta;
    logic rst_n;

    // Assertion reaches every flop at once; release is aligned to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk  (clk),
        .reset(rst_n),
        .btn  (btn),
        .press(press)
    );

    game_state_t        state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SCORE_W-1:0] score_d;
    logic               halt_d;
    logic               scroll_reset_d;
    logic               jump_d;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        hold_d         = hold_q;
        score_d        = score;
        scroll_reset_d = 1'b0;
        jump_d         = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (press) begin
                    state_d        = S_RUN;
                    score_d        = '0;
                    tick_d         = '0;
                    hold_d         = '0;
                    scroll_reset_d = 1'b1;
                end
            end
            S_RUN: begin
                if (collision) begin
                    state_d = S_DEAD;
                    tick_d  = '0;
                    hold_d  = '0;
                end else begin
                    jump_d = press;
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        score_d = score_inc(score);
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_OVER;
                    tick_d  = '0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: ;
        endcase
        // The scroll only runs once RUN has lasted past its reset cycle.
        halt_d = !((state_q == S_RUN) && (state_d == S_RUN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            hold_q       <= '0;
            score        <= '0;
            scroll_halt  <= 1'b1;
            scroll_reset <= 1'b0;
            jump_req     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            hold_q       <= hold_d;
            score        <= score_d;
            scroll_halt  <= halt_d;
            scroll_reset <= scroll_reset_d;
            jump_req     <= jump_d;
        end
    end

    assign state = state_q;

`ifdef GAME_CTRL_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= '0;
        end else if ((state_q == S_RUN) && (state_d == S_DEAD) && (score > high_q)) begin
            high_q <= score;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random button/collision traffic
// compared cycle by cycle against a behavioural game model.
module tb_game_ctrl;

    localparam int D = 4;
    localparam int H = 20;
    localparam int S = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic        collision;
    logic        scroll_halt;
    logic        scroll_reset;
    logic        jump_req;
    logic [1:0]  state;
    logic [13:0] score;
    logic [13:0] high_score;

    always #5 clk = ~clk;

    game_ctrl #(
        .DEBOUNCE_CYC(D),
        .HOLDOFF_CYC (H),
        .SCORE_CYC   (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .collision   (collision),
        .scroll_halt (scroll_halt),
        .scroll_reset(scroll_reset),
        .jump_req    (jump_req),
        .state       (state),
        .score       (score),
        .high_score  (high_score)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model: game rules in terms of elapsed cycles, button as a sample window.
    int m_state, m_halt, m_sreset, m_jump, m_score, m_high;
    int run_cyc, dead_cyc;
    bit lv1, lv2, pr;
    bit hist[$];

    task automatic model_reset();
        m_state  = 0;
        m_halt   = 1;
        m_sreset = 0;
        m_jump   = 0;
        m_score  = 0;
        m_high   = 0;
        run_cyc  = 0;
        dead_cyc = 0;
        lv1      = 0;
        lv2      = 0;
        pr       = 0;
        hist.delete();
        repeat (D + 3) hist.push_back(1'b0);
    endtask

    task automatic step();
        bit all_eq;
        bit new_lv;
        bit new_pr;
        m_sreset = 0;
        m_jump   = 0;
        case (m_state)
            0, 3: begin
                m_halt = 1;
                if (pr) begin
                    m_state  = 1;
                    m_sreset = 1;
                    m_score  = 0;
                    run_cyc  = 0;
                end
            end
            1: begin
                if (collision) begin
`ifdef GAME_CTRL_HIGH_SCORE_EN
                    if (m_score > m_high) m_high = m_score;
`endif
                    m_state  = 2;
                    m_halt   = 1;
                    dead_cyc = 0;
                end else begin
                    m_halt = 0;
                    m_jump = int'(pr);
                    run_cyc++;
                    if ((run_cyc % S) == 0 && m_score < 9999) m_score++;
                end
            end
            default: begin
                m_halt = 1;
                dead_cyc++;
                if (dead_cyc == H) m_state = 3;
            end
        endcase
        // Level follows the button once D+1 samples, ending two cycles back, agree.
        hist.push_back(btn);
        void'(hist.pop_front());
        all_eq = 1'b1;
        for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
        new_lv = all_eq ? hist[0] : lv1;
        new_pr = lv1 & ~lv2;
        lv2 = lv1;
        lv1 = new_lv;
        pr  = new_pr;

        @(posedge clk);
        cyc++;
        #1;
        check("state", int'(state), m_state);
        check("scroll_halt", int'(scroll_halt), m_halt);
        check("scroll_reset", int'(scroll_reset), m_sreset);
        check("jump_req", int'(jump_req), m_jump);
        check("score", int'(score), m_score);
        check("high_score", int'(high_score), m_high);
    endtask

    int rise_cyc;
    int entry_cyc;
    int dead_entry;
    int jumps;
    int hs_exp;
    int hold;

    initial begin
        reset     = 1'b0;
        btn       = 1'b0;
        collision = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", int'(state), 0);
        check("rst_halt", int'(scroll_halt), 1);
        check("rst_sreset", int'(scroll_reset), 0);
        check("rst_jump", int'(jump_req), 0);
        check("rst_score", int'(score), 0);
        check("rst_high", int'(high_score), 0);
        reset = 1'b1;

        repeat (50) step();

        // Glitchy press: 3 high, 1 low, then high for good.
        btn = 1'b1;
        repeat (3) step();
        btn = 1'b0;
        step();
        btn = 1'b1;
        rise_cyc = cyc + 1;
        for (int i = 0; i < 30 && state != 2'd1; i++) step();
        check("press_latency", cyc - rise_cyc, D + 4);
        check("entry_sreset", int'(scroll_reset), 1);
        check("entry_halt", int'(scroll_halt), 1);
        entry_cyc = cyc;
        step();
        check("halt_drop", int'(scroll_halt), 0);
        check("sreset_pulse", int'(scroll_reset), 0);

        while (cyc < entry_cyc + 100) step();
        check("score_100", int'(score), 10);

        // Second press inside RUN: one jump.
        btn = 1'b0;
        repeat (2 * D + 4) step();
        btn   = 1'b1;
        jumps = 0;
        repeat (2 * D + 4) begin
            step();
            jumps += int'(jump_req);
        end
        check("jump_count", jumps, 1);
        check("run_stays", int'(state), 1);

        // Collision in the same cycle the FSM sees a press.
        btn = 1'b0;
        repeat (2 * D + 4) step();
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pr) begin
                collision = 1'b1;
                step();
                collision = 1'b0;
                break;
            end
            step();
        end
        check("col_dead", int'(state), 2);
        check("col_no_jump", int'(jump_req), 0);
        check("col_halt", int'(scroll_halt), 1);
        dead_entry = cyc;
`ifdef GAME_CTRL_HIGH_SCORE_EN
        hs_exp = m_score;
`else
        hs_exp = 0;
`endif

        // Press during DEAD is ignored; OVER arrives exactly H cycles after entry.
        btn = 1'b0;
        repeat (D + 4) step();
        btn = 1'b1;
        while (cyc < dead_entry + H - 1) step();
        check("dead_hold", int'(state), 2);
        step();
        check("over_at_h", int'(state), 3);

        // Restart from OVER.
        btn = 1'b0;
        repeat (2 * D + 4) step();
        btn = 1'b1;
        for (int i = 0; i < 20 && state != 2'd1; i++) step();
        check("restart_run", int'(state), 1);
        check("restart_score", int'(score), 0);
        check("restart_high", int'(high_score), hs_exp);

        // Random button and collision traffic.
        repeat (60) begin
            btn  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            repeat (hold) begin
                collision = ($urandom_range(0, 39) == 0);
                step();
            end
        end
        collision = 1'b0;

        // Get back into RUN, then reset asynchronously mid-cycle.
        for (int a = 0; a < 3 && state != 2'd1; a++) begin
            btn = 1'b0;
            repeat (2 * D + 4) step();
            btn = 1'b1;
            for (int i = 0; i < 30 && state != 2'd1; i++) step();
        end
        check("pre_reset_run", int'(state), 1);
        repeat (15) step();
        #2;
        reset = 1'b0;
        btn   = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_halt", int'(scroll_halt), 1);
        check("async_sreset", int'(scroll_reset), 0);
        check("async_jump", int'(jump_req), 0);
        check("async_score", int'(score), 0);
        check("async_high", int'(high_score), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (30) step();
        check("post_reset_score", int'(score), 0);
        check("post_reset_state", int'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
